nios2_debug_ocimem_arbiter: RTL and testbench
=============================================

Name: nios2_debug_ocimem_arbiter

Overview:
Sysclk-domain controller for the Nios II on-chip-instrumentation (OCI) debug RAM. It turns the single-cycle JTAG debug commands from the debug-slave sysclk block into sequenced RAM reads and writes. It also shares the RAM's single port with the CPU's Avalon debug-memory slave, using fair alternation. It owns MonAReg (auto-incrementing JTAG address), MonDReg and monitor_ready.

Parameters:
ADDR_W, 8, OCI RAM word-address width (2^ADDR_W 32-bit words)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
take_action_ocimem_a  in  1  pulse: JTAG set address (+ optional read)
take_action_ocimem_b  in  1  pulse: JTAG write data word
take_no_action_ocimem_a  in  1  pulse: JTAG read next word
jdo  in  38  JTAG data: addr=jdo[ADDR_W+1:2], rd_on_load=jdo[0], wdata=jdo[34:3]
avs_address  in  ADDR_W  CPU word address
avs_read  in  1  CPU read request
avs_write  in  1  CPU write request
avs_writedata  in  32  CPU write data
avs_byteenable  in  4  CPU byte enables
avs_readdata  out  32  CPU read data
avs_waitrequest  out  1  Avalon wait-request
ram_addr  out  ADDR_W  RAM address
ram_wren  out  1  RAM write strobe
ram_byteen  out  4  RAM byte enables
ram_wdata  out  32  RAM write data
ram_rdata  in  32  RAM read data (1-cycle registered latency)
MonDReg  out  32  last JTAG read data
monitor_ready  out  1  high when no JTAG op is pending or in flight
jtag_overrun  out  1  sticky: JTAG command dropped

Behaviour:
- Reset values:
  - MonAReg=0, MonDReg=0, monitor_ready=1, jtag_overrun=0.
  - avs_waitrequest=1, avs_readdata=0.
  - ram_wren=0, ram_addr=0, ram_byteen=0, ram_wdata=0.
  - State=IDLE, last_grant=CPU.
- Reset mid-operation aborts the op. No RAM write is issued in the reset cycle.
- JTAG command capture:
  - Pulse precedence in the same cycle: ocimem_a > ocimem_b > no_action_a. Lower-priority pulses are dropped and set jtag_overrun.
  - ocimem_a loads MonAReg=jdo[ADDR_W+1:2] and clears jtag_overrun. If jdo[0]=1, it also queues a read.
  - ocimem_b queues a write of jdo[34:3] with byteen=4'hF.
  - no_action_a queues a read.
  - A queued op sets pend=1 and monitor_ready=0 on the next edge.
  - A queuing pulse while pend or a JTAG op is in flight is dropped and sets jtag_overrun. An ocimem_a pulse in that case still does not alter MonAReg.
- FSM states: IDLE, J_WR, J_RD, J_CAP, C_WR, C_RD, C_CAP.
- IDLE arbitration:
  - jreq = pend; creq = avs_read|avs_write.
  - Grant JTAG if jreq and (!creq or last_grant==CPU); otherwise grant CPU if creq.
  - last_grant updates on each grant. Alternation means neither side waits more than one foreign op.
- J_WR (1 cycle):
  - ram_addr=MonAReg, ram_wren=1, ram_wdata=queued data.
  - Next edge: MonAReg+1 (mod 2^ADDR_W), pend=0, monitor_ready=1, then IDLE.
- J_RD: ram_addr=MonAReg, then J_CAP.
- J_CAP: MonDReg<=ram_rdata, MonAReg+1, pend=0, monitor_ready=1, then IDLE.
- C_WR: ram_addr=avs_address, ram_wren=1, ram_byteen=avs_byteenable, avs_waitrequest=0, then IDLE.
- C_RD: ram_addr=avs_address, then C_CAP.
- C_CAP: avs_readdata=ram_rdata, avs_waitrequest=0, then IDLE.
- CPU latency: write completes in 2 cycles from request, read in 3 (waitrequest low in the last cycle). Without contention, back-to-back CPU reads give one read per 3 cycles.
- avs_waitrequest=1 in every other cycle, including IDLE.
- avs_read and avs_write both asserted: treat as read (protocol violation, not flagged).
- ram_wren is asserted only in J_WR or C_WR.
- Address wrap: MonAReg at 2^ADDR_W-1 increments to 0.

Test Plan:
- Reset, then ocimem_a with addr=0x10, jdo[0]=1 -> J_RD at addr 0x10 with RAM[0x10]=0xDEADBEEF; MonDReg=0xDEADBEEF; MonAReg=0x11; monitor_ready low for 3 cycles, then high.
- ocimem_a addr=0xFF, then ocimem_b wdata=0x12345678 -> RAM[0xFF]=0x12345678 with byteen F; MonAReg wraps to 0x00.
- CPU holds avs_read at addr 0x20 continuously while JTAG queues 3 writes -> grants alternate J,C,J,C,J; every CPU read returns correct data; waitrequest low exactly 1 cycle per read.
- CPU write with byteen=4'b0011, data 0xAAAA5555 to a word holding 0xFFFFFFFF -> RAM=0xFFFF5555; avs_waitrequest low in 2nd cycle.
- ocimem_b and no_action_a pulsed in the same cycle, then a further ocimem_b while pend=1 -> only the first write is executed, jtag_overrun=1; the next ocimem_a clears it.
- reset asserted during J_CAP -> MonDReg=0, MonAReg=0, monitor_ready=1, no ram_wren in the reset cycle or the following cycle.

Source files
------------

// File: rtl/nios2_debug_ocimem_arbiter_if.sv
// Avalon debug-memory slave bus between the CPU and the OCI RAM arbiter.
// The CPU side is the master; the arbiter is the slave.
interface nios2_debug_ocimem_arbiter_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  modport master (
    output avs_address,
    output avs_read,
    output avs_write,
    output avs_writedata,
    output avs_byteenable,
    input  avs_readdata,
    input  avs_waitrequest
  );

  modport slave (
    input  avs_address,
    input  avs_read,
    input  avs_write,
    input  avs_writedata,
    input  avs_byteenable,
    output avs_readdata,
    output avs_waitrequest
  );
endinterface

// File: rtl/nios2_debug_ocimem_arbiter.sv
// OCI debug RAM controller: sequences JTAG debug commands into RAM
// accesses and shares the single RAM port with the CPU Avalon slave using
// alternating grants. Owns MonAReg, MonDReg and monitor_ready.
module nios2_debug_ocimem_arbiter #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [37:0]       jdo,
  nios2_debug_ocimem_arbiter_if.slave avs,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wren,
  output logic [3:0]        ram_byteen,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              jtag_overrun
);

  typedef enum logic [2:0] {
    IDLE,
    J_WR,
    J_RD,
    J_CAP,
    C_WR,
    C_RD,
    C_CAP
  } state_t;

  typedef enum logic {
    GRANT_CPU,
    GRANT_JTAG
  } grant_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state_reg;
  grant_t            last_grant_reg;
  logic [ADDR_W-1:0] mon_a_reg;
  logic [31:0]       mon_d_reg;
  logic              pend_reg;
  logic              pend_wr_reg;
  logic [31:0]       pend_wdata_reg;
  logic              overrun_reg;
  logic [ADDR_W-1:0] ram_addr_reg;
  logic              ram_wren_reg;
  logic [3:0]        ram_byteen_reg;
  logic [31:0]       ram_wdata_reg;
  logic [31:0]       avs_readdata_reg;
  logic              avs_waitrequest_reg;
  logic              creq;
  logic              jdo_unused;

  assign creq       = avs.avs_read | avs.avs_write;
  assign jdo_unused = ^{jdo[37:35], jdo[1]};

  // Command capture, arbitration and RAM sequencing; all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg           <= IDLE;
      last_grant_reg      <= GRANT_CPU;
      mon_a_reg           <= '0;
      mon_d_reg           <= '0;
      pend_reg            <= 1'b0;
      pend_wr_reg         <= 1'b0;
      pend_wdata_reg      <= '0;
      overrun_reg         <= 1'b0;
      ram_addr_reg        <= '0;
      ram_wren_reg        <= 1'b0;
      ram_byteen_reg      <= '0;
      ram_wdata_reg       <= '0;
      avs_readdata_reg    <= '0;
      avs_waitrequest_reg <= 1'b1;
    end else begin
      // JTAG command capture. A pending op (queued or in flight) blocks any
      // new command; lower-priority pulses in the same cycle are dropped.
      if (take_action_ocimem_a) begin
        if (pend_reg) begin
          overrun_reg <= 1'b1;
        end else begin
          mon_a_reg   <= jdo[ADDR_W+1:2];
          overrun_reg <= take_action_ocimem_b | take_no_action_ocimem_a;
          if (jdo[0]) begin
            pend_reg    <= 1'b1;
            pend_wr_reg <= 1'b0;
          end
        end
      end else if (take_action_ocimem_b) begin
        if (pend_reg || take_no_action_ocimem_a) begin
          overrun_reg <= 1'b1;
        end
        if (!pend_reg) begin
          pend_reg       <= 1'b1;
          pend_wr_reg    <= 1'b1;
          pend_wdata_reg <= jdo[34:3];
        end
      end else if (take_no_action_ocimem_a) begin
        if (pend_reg) begin
          overrun_reg <= 1'b1;
        end else begin
          pend_reg    <= 1'b1;
          pend_wr_reg <= 1'b0;
        end
      end

      // Single-cycle strobes default off; the next state re-asserts them.
      ram_wren_reg        <= 1'b0;
      avs_waitrequest_reg <= 1'b1;

      case (state_reg)
        IDLE: begin
          if (pend_reg && (!creq || last_grant_reg == GRANT_CPU)) begin
            last_grant_reg <= GRANT_JTAG;
            ram_addr_reg   <= mon_a_reg;
            if (pend_wr_reg) begin
              state_reg      <= J_WR;
              ram_wren_reg   <= 1'b1;
              ram_byteen_reg <= 4'hF;
              ram_wdata_reg  <= pend_wdata_reg;
            end else begin
              state_reg <= J_RD;
            end
          end else if (creq) begin
            last_grant_reg <= GRANT_CPU;
            ram_addr_reg   <= avs.avs_address;
            // Read wins if the CPU asserts both strobes.
            if (avs.avs_read) begin
              state_reg <= C_RD;
            end else begin
              state_reg           <= C_WR;
              ram_wren_reg        <= 1'b1;
              ram_byteen_reg      <= avs.avs_byteenable;
              ram_wdata_reg       <= avs.avs_writedata;
              avs_waitrequest_reg <= 1'b0;
            end
          end
        end
        J_WR: begin
          mon_a_reg <= mon_a_reg + ADDR_ONE;
          pend_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        J_RD: begin
          state_reg <= J_CAP;
        end
        J_CAP: begin
          mon_d_reg <= ram_rdata;
          mon_a_reg <= mon_a_reg + ADDR_ONE;
          pend_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        C_WR: begin
          state_reg <= IDLE;
        end
        C_RD: begin
          avs_waitrequest_reg <= 1'b0;
          state_reg           <= C_CAP;
        end
        C_CAP: begin
          avs_readdata_reg <= ram_rdata;
          state_reg        <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // RAM data arrives during C_CAP, so it is forwarded directly in that
  // cycle and held afterwards. The write strobe is gated by reset so no
  // write can land while an op is being aborted.
  assign avs.avs_readdata    = (state_reg == C_CAP) ? ram_rdata : avs_readdata_reg;
  assign avs.avs_waitrequest = avs_waitrequest_reg;
  assign ram_addr            = ram_addr_reg;
  assign ram_wren            = ram_wren_reg & ~reset;
  assign ram_byteen          = ram_byteen_reg;
  assign ram_wdata           = ram_wdata_reg;
  assign MonDReg             = mon_d_reg;
  assign monitor_ready       = ~pend_reg;
  assign jtag_overrun        = overrun_reg;

endmodule

// File: tb/tb_nios2_debug_ocimem_arbiter.sv
// Directed bench for the OCI RAM arbiter with a 1-cycle-latency RAM model.
module tb_nios2_debug_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        ocimem_a;
  logic        ocimem_b;
  logic        no_action_a;
  logic [37:0] jdo;
  logic [7:0]  ram_addr;
  logic        ram_wren;
  logic [3:0]  ram_byteen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] mon_d;
  logic        monitor_ready;
  logic        jtag_overrun;

  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [31:0] pre_data;
  logic [31:0] mem [0:255];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nios2_debug_ocimem_arbiter_if #(.ADDR_W(8)) avs_if ();

  nios2_debug_ocimem_arbiter #(.ADDR_W(8)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .take_action_ocimem_a    (ocimem_a),
    .take_action_ocimem_b    (ocimem_b),
    .take_no_action_ocimem_a (no_action_a),
    .jdo                     (jdo),
    .avs                     (avs_if.slave),
    .ram_addr                (ram_addr),
    .ram_wren                (ram_wren),
    .ram_byteen              (ram_byteen),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (mon_d),
    .monitor_ready           (monitor_ready),
    .jtag_overrun            (jtag_overrun)
  );

  // RAM model: byte-enabled write, registered read, plus a bench preload port.
  always @(posedge clk) begin
    if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (ram_wren) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_byteen[i]) mem[ram_addr][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
    ram_rdata <= mem[ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [31:0] d);
    pre_we   = 1'b1;
    pre_addr = a;
    pre_data = d;
    tick();
    pre_we   = 1'b0;
  endtask

  function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd);
    logic [37:0] v;
    v      = '0;
    v[9:2] = a;
    v[0]   = rd;
    return v;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] w);
    logic [37:0] v;
    v       = '0;
    v[34:3] = w;
    return v;
  endfunction

  initial begin
    reset = 1'b1;
    ocimem_a = 1'b0; ocimem_b = 1'b0; no_action_a = 1'b0; jdo = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    avs_if.avs_address = '0; avs_if.avs_read = 1'b0; avs_if.avs_write = 1'b0;
    avs_if.avs_writedata = '0; avs_if.avs_byteenable = '0;
    tick();
    poke(8'h00, 32'h0); poke(8'h01, 32'h0); poke(8'h02, 32'h0);
    poke(8'h03, 32'h0); poke(8'h04, 32'h44444444);
    poke(8'h10, 32'hDEADBEEF); poke(8'h11, 32'h11112222);
    poke(8'h20, 32'hCAFEF00D); poke(8'h30, 32'hFFFFFFFF); poke(8'hFF, 32'h0);
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_mondreg", mon_d, 32'h0);
    chk("rst_ready", {31'b0, monitor_ready}, 32'h1);
    chk("rst_overrun", {31'b0, jtag_overrun}, 32'h0);
    chk("rst_waitreq", {31'b0, avs_if.avs_waitrequest}, 32'h1);
    chk("rst_readdata", avs_if.avs_readdata, 32'h0);
    chk("rst_wren", {31'b0, ram_wren}, 32'h0);
    chk("rst_addr", {24'b0, ram_addr}, 32'h0);
    chk("rst_byteen", {28'b0, ram_byteen}, 32'h0);
    chk("rst_wdata", ram_wdata, 32'h0);

    // JTAG set address 0x10 with read
    ocimem_a = 1'b1; jdo = jdo_a(8'h10, 1'b1);
    tick(); ocimem_a = 1'b0;
    chk("rd_ready_c1", {31'b0, monitor_ready}, 32'h0);
    tick();
    chk("rd_ready_c2", {31'b0, monitor_ready}, 32'h0);
    chk("rd_ram_addr", {24'b0, ram_addr}, 32'h10);
    tick();
    chk("rd_ready_c3", {31'b0, monitor_ready}, 32'h0);
    tick();
    chk("rd_ready_done", {31'b0, monitor_ready}, 32'h1);
    chk("rd_mondreg", mon_d, 32'hDEADBEEF);
    // Read-next proves MonAReg advanced to 0x11
    no_action_a = 1'b1;
    tick(); no_action_a = 1'b0;
    tick(); tick(); tick();
    chk("rd_next_mondreg", mon_d, 32'h11112222);
    chk("rd_next_ready", {31'b0, monitor_ready}, 32'h1);

    // Address 0xFF then JTAG write; MonAReg wraps to 0
    ocimem_a = 1'b1; jdo = jdo_a(8'hFF, 1'b0);
    tick(); ocimem_a = 1'b0;
    chk("seta_no_queue_ready", {31'b0, monitor_ready}, 32'h1);
    ocimem_b = 1'b1; jdo = jdo_b(32'h12345678);
    tick(); ocimem_b = 1'b0;
    tick();
    chk("jwr_wren", {31'b0, ram_wren}, 32'h1);
    chk("jwr_addr", {24'b0, ram_addr}, 32'hFF);
    chk("jwr_byteen", {28'b0, ram_byteen}, 32'hF);
    chk("jwr_wdata", ram_wdata, 32'h12345678);
    tick();
    chk("jwr_wren_off", {31'b0, ram_wren}, 32'h0);
    chk("jwr_mem_ff", mem[8'hFF], 32'h12345678);

    // CPU holds a read of 0x20 while JTAG queues three writes
    ocimem_b = 1'b1; jdo = jdo_b(32'hA0000001);
    tick(); ocimem_b = 1'b0;
    tick();
    chk("alt1_j_wren", {31'b0, ram_wren}, 32'h1);
    chk("alt1_j_addr_wrap", {24'b0, ram_addr}, 32'h00);
    avs_if.avs_address = 8'h20; avs_if.avs_read = 1'b1;
    tick();
    chk("alt_idle_wait", {31'b0, avs_if.avs_waitrequest}, 32'h1);
    ocimem_b = 1'b1; jdo = jdo_b(32'hA0000002);
    tick(); ocimem_b = 1'b0;
    chk("alt2_crd_wait", {31'b0, avs_if.avs_waitrequest}, 32'h1);
    chk("alt2_crd_addr", {24'b0, ram_addr}, 32'h20);
    tick();
    chk("alt2_ccap_wait", {31'b0, avs_if.avs_waitrequest}, 32'h0);
    chk("alt2_ccap_data", avs_if.avs_readdata, 32'hCAFEF00D);
    tick();
    chk("alt2_after_wait", {31'b0, avs_if.avs_waitrequest}, 32'h1);
    tick();
    chk("alt3_j_wren", {31'b0, ram_wren}, 32'h1);
    chk("alt3_j_addr", {24'b0, ram_addr}, 32'h01);
    chk("alt3_j_wait", {31'b0, avs_if.avs_waitrequest}, 32'h1);
    tick();
    ocimem_b = 1'b1; jdo = jdo_b(32'hA0000003);
    tick(); ocimem_b = 1'b0;
    chk("alt4_crd_wait", {31'b0, avs_if.avs_waitrequest}, 32'h1);
    tick();
    chk("alt4_ccap_wait", {31'b0, avs_if.avs_waitrequest}, 32'h0);
    chk("alt4_ccap_data", avs_if.avs_readdata, 32'hCAFEF00D);
    tick();
    avs_if.avs_read = 1'b0;
    chk("alt4_after_wait", {31'b0, avs_if.avs_waitrequest}, 32'h1);
    tick();
    chk("alt5_j_wren", {31'b0, ram_wren}, 32'h1);
    chk("alt5_j_addr", {24'b0, ram_addr}, 32'h02);
    tick();
    chk("alt_mem0", mem[0], 32'hA0000001);
    chk("alt_mem1", mem[1], 32'hA0000002);
    chk("alt_mem2", mem[2], 32'hA0000003);

    // CPU byte-enabled write
    avs_if.avs_address = 8'h30; avs_if.avs_write = 1'b1;
    avs_if.avs_byteenable = 4'b0011; avs_if.avs_writedata = 32'hAAAA5555;
    chk("cwr_wait_c1", {31'b0, avs_if.avs_waitrequest}, 32'h1);
    tick();
    chk("cwr_wait_c2", {31'b0, avs_if.avs_waitrequest}, 32'h0);
    chk("cwr_wren", {31'b0, ram_wren}, 32'h1);
    chk("cwr_byteen", {28'b0, ram_byteen}, 32'h3);
    avs_if.avs_write = 1'b0;
    tick();
    chk("cwr_wait_after", {31'b0, avs_if.avs_waitrequest}, 32'h1);
    chk("cwr_mem", mem[8'h30], 32'hFFFF5555);

    // Overrun: b + no_action together, then b while pending
    ocimem_b = 1'b1; no_action_a = 1'b1; jdo = jdo_b(32'hB0B0B0B0);
    tick(); ocimem_b = 1'b0; no_action_a = 1'b0;
    chk("ovr_set", {31'b0, jtag_overrun}, 32'h1);
    ocimem_b = 1'b1; jdo = jdo_b(32'hDEAD0000);
    tick(); ocimem_b = 1'b0;
    chk("ovr_jwr_wdata", ram_wdata, 32'hB0B0B0B0);
    chk("ovr_jwr_addr", {24'b0, ram_addr}, 32'h03);
    tick(); tick(); tick();
    chk("ovr_mem3", mem[3], 32'hB0B0B0B0);
    chk("ovr_mem4_untouched", mem[4], 32'h44444444);
    chk("ovr_sticky", {31'b0, jtag_overrun}, 32'h1);
    chk("ovr_ready", {31'b0, monitor_ready}, 32'h1);
    ocimem_a = 1'b1; jdo = jdo_a(8'h40, 1'b0);
    tick(); ocimem_a = 1'b0;
    chk("ovr_cleared", {31'b0, jtag_overrun}, 32'h0);

    // Reset during J_CAP aborts the read
    ocimem_a = 1'b1; jdo = jdo_a(8'h10, 1'b1);
    tick(); ocimem_a = 1'b0;
    tick(); tick();
    reset = 1'b1;
    chk("abort_wren_rstcyc", {31'b0, ram_wren}, 32'h0);
    tick();
    reset = 1'b0;
    chk("abort_mondreg", mon_d, 32'h0);
    chk("abort_ready", {31'b0, monitor_ready}, 32'h1);
    chk("abort_wren_next", {31'b0, ram_wren}, 32'h0);
    tick();
    chk("abort_wren_next2", {31'b0, ram_wren}, 32'h0);
    // Read-next proves MonAReg returned to 0
    no_action_a = 1'b1;
    tick(); no_action_a = 1'b0;
    tick(); tick(); tick();
    chk("abort_monareg_zero", mon_d, 32'hA0000001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
